// File: rtl/mux_8by1_using_2by1_mux_pkg.sv
// Shared constants for the 8:1 select tree.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mux_8by1_using_2by1_mux_pkg;

    // Number of data lanes feeding the tree.
    localparam int N_LANES = 8;

    // Select width: three lane-select bits plus one range bit.
    localparam int SEL_W   = 4;

    // Bit position of the range bit within the select.
    localparam int RANGE_BIT = SEL_W - 1;

endpackage

// File: rtl/mux_8by1_using_2by1_mux_mux_2by1.sv
// 2:1 lane selector, the leaf cell of the 8:1 tree.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the inputs continuously.
module mux_2by1 #(
    parameter int DATA_W = 1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sel,
    output logic [DATA_W-1:0] y
);

    // sel=0 passes a, sel=1 passes b.
    always_comb begin
        y = sel ? b : a;
    end

endmodule

// File: rtl/mux_8by1_using_2by1_mux.sv
// 8:1 lane selector built as a three-level tree of 2:1 cells, registered output.
// Latency: one clk cycle from s/i to y.
// Backpressure: none; y updates every cycle while rst is low.
module mux_8by1_using_2by1_mux
    import mux_8by1_using_2by1_mux_pkg::*;
#(
    parameter int                 DATA_W    = 1,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [DATA_W-1:0]           y,
    input  logic [SEL_W-1:0]            s,
    input  logic [N_LANES*DATA_W-1:0]   i
);

    // Intermediate tree nodes: four pair winners, two quad winners, one final.
    logic [N_LANES/2-1:0][DATA_W-1:0] lvl1;
    logic [N_LANES/4-1:0][DATA_W-1:0] lvl2;
    logic [DATA_W-1:0]                lvl3;

    genvar g;
    generate
        // Level 1: s[0] picks within lane pairs (0,1) (2,3) (4,5) (6,7).
        for (g = 0; g < N_LANES/2; g++) begin : g_lvl1
            mux_2by1 #(.DATA_W(DATA_W)) u_mux (
                .a   (i[(2*g)*DATA_W   +: DATA_W]),
                .b   (i[(2*g+1)*DATA_W +: DATA_W]),
                .sel (s[0]),
                .y   (lvl1[g])
            );
        end

        // Level 2: s[1] picks between adjacent level-1 winners.
        for (g = 0; g < N_LANES/4; g++) begin : g_lvl2
            mux_2by1 #(.DATA_W(DATA_W)) u_mux (
                .a   (lvl1[2*g]),
                .b   (lvl1[2*g+1]),
                .sel (s[1]),
                .y   (lvl2[g])
            );
        end
    endgenerate

    // Level 3: s[2] picks the lower or upper half.
    mux_2by1 #(.DATA_W(DATA_W)) u_lvl3 (
        .a   (lvl2[0]),
        .b   (lvl2[1]),
        .sel (s[2]),
        .y   (lvl3)
    );

    // Output register: reset wins, then the range bit forces zero, else the tree result.
    always_ff @(posedge clk) begin
        if (rst) begin
            y <= RESET_VAL;
        end else if (s[RANGE_BIT]) begin
            y <= '0;
        end else begin
            y <= lvl3;
        end
    end

endmodule

// File: tb/tb_mux_8by1_using_2by1_mux.sv
// Directed bench for the 8:1 registered selector.
// Latency: checks y one cycle after each applied vector.
// Backpressure: none exercised; the design has no handshake.
module tb_mux_8by1_using_2by1_mux;

    logic       clk;
    logic       rst;
    logic [0:0] y;
    logic [3:0] s;
    logic [7:0] i;

    int pass_cnt  = 0;
    int check_cnt = 0;

    mux_8by1_using_2by1_mux #(.DATA_W(1), .RESET_VAL(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .y   (y),
        .s   (s),
        .i   (i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs on the falling edge, then wait past the next rising edge.
    task automatic apply(input logic r, input logic [3:0] sv, input logic [7:0] iv);
        @(negedge clk);
        rst = r;
        s   = sv;
        i   = iv;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic exp);
        check_cnt++;
        assert (y === exp) pass_cnt++;
        else $error("FAIL %s: y=%b expected %b", tag, y, exp);
    endtask

    initial begin
        logic [3:0] sv;
        logic [7:0] one_hot;

        rst = 1'b1;
        s   = 4'b0000;
        i   = 8'h00;

        // Reset holds y at zero even though lane 5 is high.
        apply(1'b1, 4'b0101, 8'hFF);
        check("reset", 1'b0);
        apply(1'b0, 4'b0101, 8'hFF);
        check("reset_release", 1'b1);

        // Walking one across all lanes, plus inverted pattern for isolation.
        for (int k = 0; k < 8; k++) begin
            sv      = 4'(k);
            one_hot = 8'(1 << k);
            apply(1'b0, sv, 8'h00);
            check($sformatf("walk_zero_%0d", k), 1'b0);
            apply(1'b0, sv, one_hot);
            check($sformatf("walk_one_%0d", k), 1'b1);
            apply(1'b0, sv, ~one_hot);
            check($sformatf("walk_others_%0d", k), 1'b0);
        end

        // Explicit lane-3 example.
        apply(1'b0, 4'b0011, 8'b0000_1000);
        check("lane3_example", 1'b1);

        // Isolation on lane 2.
        apply(1'b0, 4'b0010, 8'b1111_1011);
        check("iso_lane2_low", 1'b0);
        apply(1'b0, 4'b0010, 8'b0000_0100);
        check("iso_lane2_high", 1'b1);

        // Range bit forces zero for every low-select value.
        for (int r = 8; r < 16; r++) begin
            sv = 4'(r);
            apply(1'b0, sv, 8'hFF);
            check($sformatf("range_%0d", r), 1'b0);
        end

        // Back-to-back select changes; lanes 0,3,4,7 high.
        apply(1'b0, 4'd0, 8'b1001_1001); check("b2b_hi_s0", 1'b1);
        apply(1'b0, 4'd7, 8'b1001_1001); check("b2b_hi_s7", 1'b1);
        apply(1'b0, 4'd3, 8'b1001_1001); check("b2b_hi_s3", 1'b1);
        apply(1'b0, 4'd4, 8'b1001_1001); check("b2b_hi_s4", 1'b1);
        apply(1'b0, 4'd0, 8'b0110_0110); check("b2b_lo_s0", 1'b0);
        apply(1'b0, 4'd7, 8'b0110_0110); check("b2b_lo_s7", 1'b0);
        apply(1'b0, 4'd3, 8'b0110_0110); check("b2b_lo_s3", 1'b0);
        apply(1'b0, 4'd4, 8'b0110_0110); check("b2b_lo_s4", 1'b0);

        // s and i change together: new values used at the next edge.
        apply(1'b0, 4'd6, 8'b0100_0000); check("same_cycle_s6", 1'b1);
        apply(1'b0, 4'd1, 8'b0000_0001); check("same_cycle_s1", 1'b0);

        // Mid-stream reset pulse with lane 7 selected and high.
        apply(1'b0, 4'b0111, 8'h80); check("mid_before", 1'b1);
        apply(1'b1, 4'b0111, 8'h80); check("mid_reset", 1'b0);
        apply(1'b0, 4'b0111, 8'h80); check("mid_after", 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
